// File: rtl/vga_timing_pkg.sv
// ============================================================================
//  Module      : vga_timing_pkg
//  Description : Default 640x480@60 raster timing constants and helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_timing_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic SYNC_ACTIVE = 1'b0;

    // Integer compare so a window ending exactly at 1024 cannot alias to 0.
    function automatic logic in_window(input logic [9:0] pos, input int lo, input int len);
        return (int'(pos) >= lo) && (int'(pos) < lo + len);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_delay_line.sv
// ============================================================================
//  Module      : sync_delay_line
//  Description : DEPTH-stage 1-bit delay, idle-high reset; DEPTH=0 is a wire.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_delay_line #(
    parameter int DEPTH = 1
) (
    input  logic vga_clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    if (DEPTH == 0) begin : g_wire
        assign dout = din;
    end else begin : g_pipe
        logic [DEPTH-1:0] r_stage;

        always_ff @(posedge vga_clk or negedge reset_n) begin
            if (!reset_n) begin
                r_stage <= '1;
            end else begin
                r_stage[0] <= din;
                for (int i = 1; i < DEPTH; i++) begin
                    r_stage[i] <= r_stage[i-1];
                end
            end
        end

        assign dout = r_stage[DEPTH-1];
    end

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Free-running VGA raster counters, blank, delayed hs/vs and a
//                per-frame vblank tick. VGA_FRAME_CNT_EN adds a frame counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_gen #(
    parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
    parameter int H_FP      = vga_timing_pkg::H_FP,
    parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int H_BP      = vga_timing_pkg::H_BP,
    parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
    parameter int V_FP      = vga_timing_pkg::V_FP,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_BP      = vga_timing_pkg::V_BP,
    parameter int SYNC_DLY  = 1
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        blank,
    output logic        hs,
    output logic        vs,
    output logic        vblank_tick,
    output logic [15:0] frame_cnt
);

    import vga_timing_pkg::*;

    localparam int c_h_total = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int c_v_total = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] c_h_last = 10'(c_h_total - 1);
    localparam logic [9:0] c_v_last = 10'(c_v_total - 1);

    if (c_h_total > 1024) begin : g_chk_h_total
        $error("vga_timing_gen: H_TOTAL exceeds 1024");
    end
    if (c_v_total > 1024) begin : g_chk_v_total
        $error("vga_timing_gen: V_TOTAL exceeds 1024");
    end
    if (SYNC_DLY < 0 || SYNC_DLY > 4) begin : g_chk_sync_dly
        $error("vga_timing_gen: SYNC_DLY must be 0..4");
    end

    logic [9:0] r_x;
    logic [9:0] r_y;
    logic [9:0] w_x_nxt;
    logic [9:0] w_y_nxt;
    logic       r_blank;
    logic       r_hs_raw;
    logic       r_vs_raw;
    logic       r_vblank_tick;

    always_comb begin
        w_x_nxt = r_x + 10'd1;
        w_y_nxt = r_y;
        if (r_x == c_h_last) begin
            w_x_nxt = '0;
            w_y_nxt = (r_y == c_v_last) ? '0 : r_y + 10'd1;
        end
    end

    // Every registered output is decoded from the next-state position so it
    // lines up with DrawX/DrawY in the same cycle.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x           <= '0;
            r_y           <= '0;
            r_blank       <= 1'b0;
            r_hs_raw      <= ~SYNC_ACTIVE;
            r_vs_raw      <= ~SYNC_ACTIVE;
            r_vblank_tick <= 1'b0;
        end else begin
            r_x           <= w_x_nxt;
            r_y           <= w_y_nxt;
            r_blank       <= in_window(w_x_nxt, 0, H_VISIBLE) && in_window(w_y_nxt, 0, V_VISIBLE);
            r_hs_raw      <= in_window(w_x_nxt, H_VISIBLE + H_FP, H_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_vs_raw      <= in_window(w_y_nxt, V_VISIBLE + V_FP, V_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_vblank_tick <= (w_x_nxt == '0) && in_window(w_y_nxt, V_VISIBLE, 1);
        end
    end

    sync_delay_line #(
        .DEPTH (SYNC_DLY)
    ) u_hs_dly (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .din     (r_hs_raw),
        .dout    (hs)
    );

    sync_delay_line #(
        .DEPTH (SYNC_DLY)
    ) u_vs_dly (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .din     (r_vs_raw),
        .dout    (vs)
    );

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_cnt <= '0;
        end else if (r_vblank_tick) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`else
    assign frame_cnt = 16'h0000;
`endif

    assign DrawX       = r_x;
    assign DrawY       = r_y;
    assign blank       = r_blank;
    assign vblank_tick = r_vblank_tick;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Self-checking bench for vga_timing_gen on a reduced raster.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_timing_gen;

    localparam int HV = 20;
    localparam int HF = 3;
    localparam int HS = 5;
    localparam int HB = 4;
    localparam int VV = 12;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int D  = 1;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FT = HT * VT;

    logic        vga_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        blank;
    logic        hs;
    logic        vs;
    logic        vblank_tick;
    logic [15:0] frame_cnt;

    int n_checks = 0;
    int n_errors = 0;

    vga_timing_gen #(
        .H_VISIBLE (HV), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_VISIBLE (VV), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SYNC_DLY  (D)
    ) dut (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .blank       (blank),
        .hs          (hs),
        .vs          (vs),
        .vblank_tick (vblank_tick),
        .frame_cnt   (frame_cnt)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // Reference model: everything follows from n, the number of clock edges
    // since reset release, because the raster is a plain modulo count.
    int n = 0;
    always @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) n <= 0;
        else          n <= n + 1;
    end

    function automatic int m_x(input int m);
        return m % HT;
    endfunction

    function automatic int m_y(input int m);
        return (m / HT) % VT;
    endfunction

    function automatic int m_hs(input int m);
        if (m <= 0) return 1;
        return (m_x(m) >= HV + HF && m_x(m) < HV + HF + HS) ? 0 : 1;
    endfunction

    function automatic int m_vs(input int m);
        if (m <= 0) return 1;
        return (m_y(m) >= VV + VF && m_y(m) < VV + VF + VS) ? 0 : 1;
    endfunction

    function automatic int m_blank(input int m);
        if (m == 0) return 0;
        return (m_x(m) < HV && m_y(m) < VV) ? 1 : 0;
    endfunction

    function automatic int m_tick(input int m);
        return (m > 0 && m_x(m) == 0 && m_y(m) == VV) ? 1 : 0;
    endfunction

    // Ticks fall at VV*HT + k*FT; the counter shows those strictly before m.
    function automatic int m_fc(input int m);
`ifdef VGA_FRAME_CNT_EN
        if (m - 1 < VV * HT) return 0;
        return ((m - 1 - VV * HT) / FT + 1) % 65536;
`else
        return 0;
`endif
    endfunction

    int last_tick = -1;
    int hs_run    = 0;
    int vs_run    = 0;
    int bcount    = 0;

    always @(negedge vga_clk) begin
        chk("DrawX",       int'(DrawX),       m_x(n));
        chk("DrawY",       int'(DrawY),       m_y(n));
        chk("blank",       int'(blank),       m_blank(n));
        chk("hs",          int'(hs),          m_hs(n - D));
        chk("vs",          int'(vs),          m_vs(n - D));
        chk("vblank_tick", int'(vblank_tick), m_tick(n));
        chk("frame_cnt",   int'(frame_cnt),   m_fc(n));
        if (!reset_n) begin
            last_tick = -1;
            hs_run    = 0;
            vs_run    = 0;
            bcount    = 0;
        end else begin
            if (vblank_tick) begin
                if (last_tick >= 0) chk("tick_gap", n - last_tick, FT);
                last_tick = n;
            end
            if (!hs) hs_run++;
            else if (hs_run > 0) begin
                chk("hs_width", hs_run, HS);
                hs_run = 0;
            end
            if (!vs) vs_run++;
            else if (vs_run > 0) begin
                chk("vs_width", vs_run, VS * HT);
                vs_run = 0;
            end
            if (n >= 1 && n <= FT) bcount += int'(blank);
            if (n == FT) chk("blank_per_frame", bcount, HV * VV);
        end
    end

    task automatic check_reset_now(input string tag);
        chk({tag, "_DrawX"},     int'(DrawX),       0);
        chk({tag, "_DrawY"},     int'(DrawY),       0);
        chk({tag, "_blank"},     int'(blank),       0);
        chk({tag, "_hs"},        int'(hs),          1);
        chk({tag, "_vs"},        int'(vs),          1);
        chk({tag, "_tick"},      int'(vblank_tick), 0);
        chk({tag, "_frame_cnt"}, int'(frame_cnt),   0);
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (10) @(negedge vga_clk);
        check_reset_now("rst_hold");
        #2 reset_n = 1'b1;
        @(negedge vga_clk);
        chk("first_DrawX", int'(DrawX), 1);
        chk("first_blank", int'(blank), 1);

        repeat (3 * FT + 100) @(negedge vga_clk);
`ifdef VGA_FRAME_CNT_EN
        chk("fc_after_3_frames", int'(frame_cnt), 3);
`else
        chk("fc_after_3_frames", int'(frame_cnt), 0);
`endif
        #2 reset_n = 1'b0;
        #1 check_reset_now("async_rst");
        repeat (3) @(negedge vga_clk);
        #2 reset_n = 1'b1;

        for (int it = 0; it < 4; it++) begin
            repeat ($urandom_range(50, 2 * FT)) @(negedge vga_clk);
            #2 reset_n = 1'b0;
            #1 check_reset_now("rand_rst");
            repeat ($urandom_range(1, 5)) @(negedge vga_clk);
            #2 reset_n = 1'b1;
        end
        repeat (FT + 10) @(negedge vga_clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
